// File: rtl/uart_paint_ctrl_if.sv
// Handshake bundle between the paint command controller, the UART byte core
// and the framebuffer port.
interface uart_paint_ctrl_if #(
   parameter int ADDR_W = 12
);
   logic [7:0]        rx_data;
   logic              rx_avail;
   logic              rx_error;
   logic              rx_ack;
   logic [7:0]        tx_data;
   logic              tx_wr;
   logic              tx_busy;
   logic              px_we;
   logic              px_re;
   logic [ADDR_W-1:0] px_addr;
   logic [7:0]        px_wdata;
   logic [7:0]        px_rdata;
   logic              px_rvalid;

   modport master (
      input  rx_data, rx_avail, rx_error, tx_busy, px_rdata, px_rvalid,
      output rx_ack, tx_data, tx_wr, px_we, px_re, px_addr, px_wdata
   );

   modport slave (
      output rx_data, rx_avail, rx_error, tx_busy, px_rdata, px_rvalid,
      input  rx_ack, tx_data, tx_wr, px_we, px_re, px_addr, px_wdata
   );
endinterface

// File: rtl/uart_paint_ctrl.sv
// Paint command controller: parses 6-byte UART frames (AA cmd x y color chk),
// runs pixel write/clear/read on the framebuffer and answers with one byte.
module uart_paint_ctrl #(
   parameter int WIDTH   = 64,
   parameter int HEIGHT  = 64,
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 500000
) (
   input  logic              clk,
   input  logic              reset,
   uart_paint_ctrl_if.master bus,
   output logic              busy
);
   localparam logic [7:0]        SYNC_BYTE = 8'hAA;
   localparam logic [7:0]        ACK_BYTE  = 8'h06;
   localparam logic [7:0]        NAK_BYTE  = 8'h15;
   localparam int                TO_W      = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
   localparam logic [8:0]        W_LIM     = 9'(WIDTH);
   localparam logic [8:0]        H_LIM     = 9'(HEIGHT);

   typedef enum logic [2:0] {
      HUNT, COLLECT, CHECK, WRITE, CLEAR, READ, RESP, RESP_WAIT
   } state_t;

   state_t            r_state, w_state_next;
   logic [4:0][7:0]   r_fld, w_fld_next;
   logic [2:0]        r_idx, w_idx_next;
   logic [TO_W-1:0]   r_gap, w_gap_next;
   logic [7:0]        r_resp, w_resp_next;
   logic              r_skip, w_skip_next;
   logic              r_rx_ack, w_rx_ack_next;
   logic [7:0]        r_tx_data, w_tx_data_next;
   logic              r_tx_wr, w_tx_wr_next;
   logic              r_px_we, w_px_we_next;
   logic              r_px_re, w_px_re_next;
   logic [ADDR_W-1:0] r_px_addr, w_px_addr_next;
   logic [7:0]        r_px_wdata, w_px_wdata_next;
   logic              r_busy, w_busy_next;

   // Frame fields in arrival order after the sync byte.
   logic [7:0]        w_cmd, w_x, w_y, w_color, w_chk;
   logic              w_take, w_err, w_chk_ok, w_in_range;
   logic [ADDR_W-1:0] w_pix_addr;

   assign w_cmd   = r_fld[0];
   assign w_x     = r_fld[1];
   assign w_y     = r_fld[2];
   assign w_color = r_fld[3];
   assign w_chk   = r_fld[4];

   // r_rx_ack high marks the guard cycle: the UART still shows the old byte.
   assign w_take     = bus.rx_avail && !r_rx_ack;
   assign w_err      = bus.rx_error && !r_rx_ack;
   assign w_chk_ok   = ((w_cmd ^ w_x ^ w_y ^ w_color) == w_chk);
   assign w_in_range = ({1'b0, w_x} < W_LIM) && ({1'b0, w_y} < H_LIM);
   assign w_pix_addr = ADDR_W'(int'(w_y) * WIDTH + int'(w_x));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= HUNT;
         r_fld      <= '0;
         r_idx      <= '0;
         r_gap      <= '0;
         r_resp     <= '0;
         r_skip     <= 1'b0;
         r_rx_ack   <= 1'b0;
         r_tx_data  <= '0;
         r_tx_wr    <= 1'b0;
         r_px_we    <= 1'b0;
         r_px_re    <= 1'b0;
         r_px_addr  <= '0;
         r_px_wdata <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_fld      <= w_fld_next;
         r_idx      <= w_idx_next;
         r_gap      <= w_gap_next;
         r_resp     <= w_resp_next;
         r_skip     <= w_skip_next;
         r_rx_ack   <= w_rx_ack_next;
         r_tx_data  <= w_tx_data_next;
         r_tx_wr    <= w_tx_wr_next;
         r_px_we    <= w_px_we_next;
         r_px_re    <= w_px_re_next;
         r_px_addr  <= w_px_addr_next;
         r_px_wdata <= w_px_wdata_next;
         r_busy     <= w_busy_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_fld_next      = r_fld;
      w_idx_next      = r_idx;
      w_gap_next      = r_gap;
      w_resp_next     = r_resp;
      w_skip_next     = 1'b0;
      w_rx_ack_next   = 1'b0;
      w_tx_data_next  = r_tx_data;
      w_tx_wr_next    = 1'b0;
      w_px_we_next    = 1'b0;
      w_px_re_next    = 1'b0;
      w_px_addr_next  = r_px_addr;
      w_px_wdata_next = r_px_wdata;

      case (r_state)
         HUNT: begin
            if (w_err) begin
               w_rx_ack_next = 1'b1;
            end else if (w_take) begin
               w_rx_ack_next = 1'b1;
               if (bus.rx_data == SYNC_BYTE) begin
                  w_state_next = COLLECT;
                  w_idx_next   = '0;
                  w_gap_next   = '0;
               end
            end
         end

         COLLECT: begin
            if (w_err) begin
               w_rx_ack_next = 1'b1;
               w_state_next  = HUNT;
            end else if (w_take) begin
               w_rx_ack_next     = 1'b1;
               w_fld_next[r_idx] = bus.rx_data;
               w_gap_next        = '0;
               if (r_idx == 3'd4) begin
                  w_state_next = CHECK;
               end else begin
                  w_idx_next = r_idx + 3'd1;
               end
            end else if (r_gap == TO_W'(TIMEOUT - 1)) begin
               w_state_next = HUNT;
            end else begin
               w_gap_next = r_gap + TO_W'(1);
            end
         end

         CHECK: begin
            w_state_next = RESP;
            w_resp_next  = NAK_BYTE;
            if (w_chk_ok) begin
               case (w_cmd)
                  8'h01: begin
                     if (w_in_range) begin
                        w_state_next    = WRITE;
                        w_resp_next     = ACK_BYTE;
                        w_px_we_next    = 1'b1;
                        w_px_addr_next  = w_pix_addr;
                        w_px_wdata_next = w_color;
                     end
                  end
                  8'h02: begin
                     w_state_next    = CLEAR;
                     w_resp_next     = ACK_BYTE;
                     w_px_we_next    = 1'b1;
                     w_px_addr_next  = '0;
                     w_px_wdata_next = w_color;
                  end
                  8'h03: begin
                     if (w_in_range) begin
                        w_state_next   = READ;
                        w_px_re_next   = 1'b1;
                        w_px_addr_next = w_pix_addr;
                     end
                  end
                  default: ;
               endcase
            end
         end

         WRITE: begin
            w_state_next = RESP;
         end

         CLEAR: begin
            // The cycle currently writing the last address ends the sweep.
            if (r_px_addr == LAST_ADDR) begin
               w_state_next = RESP;
            end else begin
               w_px_we_next   = 1'b1;
               w_px_addr_next = r_px_addr + ADDR_W'(1);
            end
         end

         READ: begin
            if (bus.px_rvalid) begin
               w_resp_next  = bus.px_rdata;
               w_state_next = RESP;
            end
         end

         RESP: begin
            if (!bus.tx_busy) begin
               w_tx_wr_next   = 1'b1;
               w_tx_data_next = r_resp;
               w_skip_next    = 1'b1;
               w_state_next   = RESP_WAIT;
            end
         end

         RESP_WAIT: begin
            // The transmitter raises tx_busy a cycle after tx_wr, so ignore it once.
            if (!r_skip && !bus.tx_busy) begin
               w_state_next = HUNT;
            end
         end

         default: begin
            w_state_next = HUNT;
         end
      endcase

      w_busy_next = (w_state_next != HUNT);
   end

   assign bus.rx_ack   = r_rx_ack;
   assign bus.tx_data  = r_tx_data;
   assign bus.tx_wr    = r_tx_wr;
   assign bus.px_we    = r_px_we;
   assign bus.px_re    = r_px_re;
   assign bus.px_addr  = r_px_addr;
   assign bus.px_wdata = r_px_wdata;
   assign busy         = r_busy;

endmodule
